// File: rtl/select_decoder5to32_if.sv
// Request/response bundle for the 5-to-32 select decoder.
// The requester drives the master side; the decoder sits on the slave side.
interface select_decoder5to32_if;
    logic        req_valid;
    logic [4:0]  req_idx;
    logic        req_ready;
    logic [31:0] dout;
    logic        busy;
    logic        done;

    modport master (
        output req_valid,
        output req_idx,
        input  req_ready,
        input  dout,
        input  busy,
        input  done
    );

    modport slave (
        input  req_valid,
        input  req_idx,
        output req_ready,
        output dout,
        output busy,
        output done
    );
endinterface

// File: rtl/select_decoder5to32.sv
// Sequential 5-to-32 one-hot select decoder with break-before-make dead time.
// A request is accepted only while idle. The decoded enable line is held for
// HOLD_CYCLES cycles. Then it is released with a one-cycle done pulse. An
// optional GAP_CYCLES idle stretch follows before the next request is taken.
module select_decoder5to32 #(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0
) (
    input logic                  clk,
    input logic                  clr,
    select_decoder5to32_if.slave bus
);

    localparam int MAX_COUNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW        = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   dout_q,  dout_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    // Next-state logic: accept in IDLE, count down the drive window, then the gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                dout_d = '0;
                busy_d = 1'b0;
                if (bus.req_valid) begin
                    dout_d  = 32'h1 << bus.req_idx;
                    busy_d  = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    dout_d = '0;
                    done_d = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end

            GAP: begin
                dout_d = '0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dout_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; clr wins over everything and suppresses done.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.dout      = dout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_select_decoder5to32.sv
// Bench for select_decoder5to32. Two instances with different timing share one
// request stream: dut0 uses HOLD=1/GAP=0 and dut1 uses HOLD=3/GAP=2. A
// timeline model tracks the edges since each instance's last accept. Accepted
// indices are queued and matched whenever a drive window appears on dout.
module tb_select_decoder5to32;

    localparam int HOLD0  = 1;
    localparam int GAP0   = 0;
    localparam int HOLD1  = 3;
    localparam int GAP1   = 2;
    localparam int IDLE_K = 1_000_000;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    select_decoder5to32_if bus0 ();
    select_decoder5to32_if bus1 ();

    select_decoder5to32 #(.HOLD_CYCLES(HOLD0), .GAP_CYCLES(GAP0)) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (bus0.slave)
    );

    select_decoder5to32 #(.HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1.slave)
    );

    int errors = 0;
    int checks = 0;

    int holdP [2] = '{HOLD0, HOLD1};
    int gapP  [2] = '{GAP0, GAP1};

    // Edges since the last accept, or IDLE_K when no window is pending.
    int          kCnt   [2] = '{IDLE_K, IDLE_K};
    logic [4:0]  curIdx [2] = '{5'd0, 5'd0};
    logic [31:0] prevDout [2] = '{32'h0, 32'h0};

    logic [4:0] expQ0 [$];
    logic [4:0] expQ1 [$];

    task automatic compare(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    // The timeline model advances on each edge. A request is accepted once more
    // than HOLD+GAP edges have passed since the previous accept.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                kCnt[d] <= IDLE_K;
            end else if (kCnt[d] > holdP[d] + gapP[d] && bus0.req_valid) begin
                kCnt[d]   <= 1;
                curIdx[d] <= bus0.req_idx;
                if (d == 0) expQ0.push_back(bus0.req_idx);
                else        expQ1.push_back(bus0.req_idx);
            end else if (kCnt[d] < IDLE_K) begin
                kCnt[d] <= kCnt[d] + 1;
            end
        end
    end

    task automatic checkOutput(input int d, input logic [31:0] dout, input logic busy,
                               input logic done, input logic ready);
        int          k;
        logic [31:0] expDout;
        logic        expBusy;
        logic        expDone;
        logic [4:0]  popped;
        k       = kCnt[d];
        expDout = (k >= 1 && k <= holdP[d]) ? (32'h1 << curIdx[d]) : 32'h0;
        expDone = (k == holdP[d] + 1);
        expBusy = (k >= 1 && k <= holdP[d] + gapP[d]);

        compare("dout", d, dout, expDout);
        compare("busy", d, {31'b0, busy}, {31'b0, expBusy});
        compare("done", d, {31'b0, done}, {31'b0, expDone});
        compare("req_ready", d, {31'b0, ready}, {31'b0, !expBusy});
        compare("onehot_or_zero", d, {31'b0, ($countones(dout) <= 1)}, 32'h1);

        // Scoreboard: each new drive window consumes one accepted index.
        if (dout != 32'h0 && prevDout[d] == 32'h0) begin
            if ((d == 0 && expQ0.size() == 0) || (d == 1 && expQ1.size() == 0)) begin
                compare("unexpected_window", d, dout, 32'h0);
            end else begin
                popped = (d == 0) ? expQ0.pop_front() : expQ1.pop_front();
                compare("window_index", d, dout, 32'h1 << popped);
            end
        end
        prevDout[d] = dout;
    endtask

    // Monitor samples both instances half a cycle after each edge.
    always @(negedge clk) begin
        checkOutput(0, bus0.dout, bus0.busy, bus0.done, bus0.req_ready);
        checkOutput(1, bus1.dout, bus1.busy, bus1.done, bus1.req_ready);
    end

    task automatic applyStimulus(input logic c, input logic v, input logic [4:0] idx);
        @(negedge clk);
        clr            = c;
        bus0.req_valid = v;
        bus0.req_idx   = idx;
        bus1.req_valid = v;
        bus1.req_idx   = idx;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        clr            = 1'b1;
        bus0.req_valid = 1'b1;
        bus0.req_idx   = 5'd5;
        bus1.req_valid = 1'b1;
        bus1.req_idx   = 5'd5;

        // Reset held with a pending request, then the request goes through.
        applyStimulus(1'b1, 1'b1, 5'd5);
        applyStimulus(1'b0, 1'b1, 5'd5);
        idleCycles(8);

        // Single request.
        applyStimulus(1'b0, 1'b1, 5'd13);
        idleCycles(8);

        // Extreme indices.
        applyStimulus(1'b0, 1'b1, 5'd0);
        idleCycles(8);
        applyStimulus(1'b0, 1'b1, 5'd31);
        idleCycles(8);

        // Valid held high while the index changes every cycle.
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1, 5'(i * 7 + 3));
        idleCycles(8);

        // Reset during the second drive cycle, then a fresh request.
        applyStimulus(1'b0, 1'b1, 5'd9);
        applyStimulus(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd7);
        idleCycles(8);

        // Random soak with sparse reset.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 5'($urandom));
        end
        idleCycles(10);

        @(posedge clk);
        #1;
        compare("pending_queue", 0, 32'(expQ0.size()), 32'h0);
        compare("pending_queue", 1, 32'(expQ1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/select_decoder5to32.md
Name: select_decoder5to32

Overview:
- Sequential 5-to-32 one-hot decoder for bus source/destination selection.
- It is the inverse partner of the 32-to-5 priority encoder on the CPU data bus.
- Accepts a 5-bit register/source index over a valid/ready handshake and drives exactly one of 32 enable lines for a programmable number of cycles.
- Then inserts a guaranteed dead time, so two bus drivers are never enabled together (break-before-make).

Parameters:
- HOLD_CYCLES, 1, cycles the one-hot enable stays asserted per request; legal range >= 1.
- GAP_CYCLES, 0, extra idle cycles after deassertion before a new request is accepted; legal range >= 0.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_idx  input  5  index to decode; sampled only on accept.
- req_ready  output  1  block can accept; high exactly when FSM is IDLE.
- dout  output  32  registered one-hot enable, or all zero.
- busy  output  1  high while FSM is not IDLE.
- done  output  1  one-cycle pulse marking end of a drive window.

Behaviour:
- Reset (clr high at an edge): state = IDLE, dout = 32'h0, busy = 0, done = 0, counter = 0.
  - req_ready reads 1 after reset.
  - clr has priority over every other input.
- FSM states: IDLE, DRIVE, GAP. State, dout, busy, done and counter are all registered; req_ready is decoded from state only.
- IDLE:
  - On an edge with req_valid && req_ready: latch req_idx, dout <= 1 << req_idx, busy <= 1, counter <= HOLD_CYCLES-1, go to DRIVE.
  - Otherwise dout stays 0 and busy stays 0.
- DRIVE:
  - dout holds its value.
  - If counter != 0: counter decrements.
  - If counter == 0 at the edge: dout <= 0, done <= 1 for one cycle.
    - GAP_CYCLES == 0: go to IDLE, busy <= 0.
    - GAP_CYCLES > 0: go to GAP with counter <= GAP_CYCLES-1; busy stays 1.
- GAP:
  - dout stays 0; counter decrements.
  - When counter == 0 at the edge: go to IDLE, busy <= 0.
- Latency, with accept at edge E:
  - dout is one-hot for exactly HOLD_CYCLES cycles, starting the cycle after E.
  - done is high in the first cycle dout returns to 0.
  - req_ready rises in that same cycle when GAP_CYCLES == 0, otherwise GAP_CYCLES cycles later.
- Back-to-back requests: minimum spacing between accepts is HOLD_CYCLES + GAP_CYCLES + 1 edges. At least one all-zero dout cycle always separates two drive windows.
- Invariant: dout is always zero or exactly one-hot, never multi-hot, including across reset and back-to-back requests.
- Index mapping: all 32 indices are legal, including 0 (dout = 32'h0000_0001) and 31 (dout = 32'h8000_0000). There is no priority or masking.
- Inputs during a window: req_idx and req_valid changes while busy are ignored. No request is queued; the requester must hold req_valid until req_ready.
- done and req_valid in the same cycle: the request is accepted if req_ready is high (GAP_CYCLES == 0). done is unaffected.
- clr mid-DRIVE or mid-GAP: dout goes to 0 at that edge and no done pulse is produced. The next request is accepted normally afterward.
- Counter width: clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1), minimum 1 bit.

Test Plan:
- Reset, defaults: assert clr 2 cycles with req_valid=1, req_idx=5 -> dout=0, busy=0, done=0 throughout; req_ready=1 after clr drops; the request is accepted on the first edge after clr.
- Single request, HOLD=1, GAP=0: req_idx=5'd13 accepted at edge E -> dout=32'h0000_2000 for 1 cycle, then dout=0 with done=1 and req_ready=1; re-accept is possible at the next edge.
- Boundaries, HOLD=3: indices 0 and 31 -> dout=32'h0000_0001 for 3 cycles, then 32'h8000_0000 for 3 cycles; at least one zero cycle between them; done pulses exactly twice.
- Gap and ignored inputs, HOLD=2, GAP=2: req_valid held high with req_idx changing every cycle -> only indices sampled while req_ready=1 are driven; accept spacing is exactly 5 edges; dout never multi-hot (checked with a popcount assertion on every cycle).
- Reset mid-operation, HOLD=4: clr pulsed during the 2nd drive cycle -> dout=0 and busy=0 the next cycle, no done pulse; a following request for idx 7 yields 32'h0000_0080 for 4 cycles.
- Random soak: 10k cycles with random req_valid, req_idx and sparse clr -> the scoreboard matches every accepted index to exactly one HOLD-length window and one done pulse; the one-hot/zero invariant is never violated.
